sia_rxq_wm: RTL and testbench
=============================

// Module: sia_rxq_wm
// PURPOSE
//  Parametrised receive queue for the SIA V.4 serial interface; next generation of the plain RX FIFO wrapper.
//  Sits between the sia_receiver (word + idle outputs) and the Wishbone register slave.
//  Adds: spurious-push suppression after reset, overrun detection with drop counter, fill level,
//  programmable watermark, character-timeout flag, synchronous flush.
// PARAMETERS
//  DATA_BITS   16  width of one received word
//  DEPTH_BITS  4   log2 of FIFO depth (depth = 2**DEPTH_BITS entries)
//  TMO_BITS    16  width of character-timeout counter/threshold
//  OVC_BITS    8   width of saturating overrun drop counter
// PORTS
//  clk_i        in   1            system clock, all logic on rising edge
//  reset_i      in   1            synchronous, active-high reset
//  rx_dat_i     in   DATA_BITS    word from receiver shift register
//  rx_idle_i    in   1            receiver idle; rising edge = word complete
//  pop_i        in   1            discard head entry
//  oe_i         in   1            drive head onto dat_o
//  flush_i      in   1            empty FIFO, clear timeout
//  ovr_clr_i    in   1            clear ovr_o and ovr_cnt_o
//  wm_i         in   DEPTH_BITS+1 watermark threshold; 0 disables wm_o
//  tmo_i        in   TMO_BITS     char-timeout in clk cycles; 0 disables tmo_o
//  dat_o        out  DATA_BITS    head entry when oe_i, else 0 (combinational on oe_i)
//  level_o      out  DEPTH_BITS+1 entries held, 0..2**DEPTH_BITS
//  full_o       out  1            level_o == depth
//  not_empty_o  out  1            level_o != 0
//  wm_o         out  1            wm_i != 0 && level_o >= wm_i
//  tmo_o        out  1            sticky character-timeout flag
//  ovr_o        out  1            sticky overrun flag
//  ovr_cnt_o    out  OVC_BITS     words dropped since last clear, saturates at all-ones
// BEHAVIOUR
//  - Reset: level 0, rp=wp=0, idle_dly=1 (no push if receiver idle out of reset), ovr_o=0,
//    ovr_cnt_o=0, tmo_o=0, tmo counter 0; full_o=0, not_empty_o=0, wm_o=0, dat_o=0.
//  - push = rx_idle_i & ~idle_dly; idle_dly <= rx_idle_i every cycle. Word written at wp same edge;
//    visible on dat_o / level_o next cycle (1-cycle latency).
//  - pop when level 0 ignored (no pointer move, no error). Push when full and no pop: word dropped,
//    ovr_o<=1, ovr_cnt_o+1 saturating; FIFO contents unchanged.
//  - Push+pop same cycle: not full, not empty -> both, level unchanged; full -> both, no overrun;
//    empty -> push only, level 1.
//  - Pointers DEPTH_BITS wide, wrap modulo depth; level tracked separately, DEPTH_BITS+1 wide.
//  - flush_i: rp<=wp, level<=0, tmo_o<=0, tmo counter 0; any push same cycle is discarded
//    (flush wins over push/pop). ovr state untouched.
//  - ovr_clr_i: clears ovr_o/ovr_cnt_o; a concurrent overrun wins (ovr_o=1, cnt=1).
//  - Timeout counter: reset to 0 on push, pop, flush, or level 0; else increments (saturating)
//    while level!=0. tmo_o<=1 when tmo_i!=0 and counter reaches tmo_i (the cycle counter==tmo_i-1
//    increments). tmo_o cleared by push, pop, or flush; set takes no effect in a cycle with push/pop.
//  - tmo_i/wm_i changes take effect immediately; lowering tmo_i below counter sets tmo_o next edge.
//  - reset_i mid-word: all state cleared; receiver's subsequent idle rising edge pushes normally.
// STRUCTURE
//  - Shared include sia_defs.vh: default widths (SIA_DATA_BITS, SIA_DEPTH_BITS, SIA_TMO_BITS).
//  - One sub-module: sia_rxq_fifo (RAM array, rp/wp, level, full/empty, flush); this top adds
//    edge detect, overrun, watermark, timeout. Receiver instanced by the SIA top, not here.
// TESTING
//  1 Reset with rx_idle_i=1 held 5 cycles -> level_o=0, not_empty_o=0, no push.
//  2 Idle 0->1 with rx_dat_i=16'hA55A, oe_i=1 -> next cycle dat_o=A55A, level_o=1; pop -> level 0.
//  3 Push 17 words (depth 16) -> full_o after 16th; 17th dropped, ovr_o=1, ovr_cnt_o=1, head intact;
//    push+pop while full -> level 16, ovr_cnt_o still 1; ovr_clr_i -> 0.
//  4 wm_i=4: push 3 -> wm_o=0; 4th -> wm_o=1; pop -> 0; wm_i=0 with 16 words -> wm_o=0.
//  5 tmo_i=10, one word, no activity -> tmo_o=1 exactly 10 cycles after push; pop -> tmo_o=0,
//    level 0 holds counter 0.
//  6 Flush with concurrent push at level 5 -> level_o=0, not_empty_o=0; 256 overruns -> ovr_cnt_o=8'hFF.

Source files
------------

// File: rtl/sia_rxq_wm_pkg.sv
// Shared defaults and event types for the SIA V.4 receive queue.
// The default widths live here so every SIA block picks up the same values.
package sia_rxq_wm_pkg;

    localparam int SIA_DATA_BITS  = 16;
    localparam int SIA_DEPTH_BITS = 4;
    localparam int SIA_TMO_BITS   = 16;
    localparam int SIA_OVC_BITS   = 8;

    // What the FIFO actually did on the current edge.
    typedef struct packed {
        logic push;
        logic pop;
        logic drop;
    } rxq_evt_t;

endpackage

// File: rtl/sia_rxq_fifo.sv
// Storage half of the receive queue: RAM array, read/write pointers, level and flush.
// Flush overrides push and pop; a push into a full FIFO without a pop is dropped.
module sia_rxq_fifo
    import sia_rxq_wm_pkg::*;
#(
    parameter int DATA_BITS  = SIA_DATA_BITS,
    parameter int DEPTH_BITS = SIA_DEPTH_BITS
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_BITS-1:0]  wdat_i,
    output logic [DATA_BITS-1:0]  head_o,
    output logic [DEPTH_BITS:0]   level_o,
    output logic                  full_o,
    output logic                  empty_o,
    output rxq_evt_t              evt_o
);

    localparam int                DEPTH     = 2 ** DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] DEPTH_LVL = (DEPTH_BITS + 1)'(DEPTH);

    logic [DATA_BITS-1:0]  mem_q [DEPTH];
    logic [DEPTH_BITS-1:0] rp_q, wp_q;
    logic [DEPTH_BITS:0]   level_q;
    logic                  wr_ok, rd_ok;

    assign full_o  = (level_q == DEPTH_LVL);
    assign empty_o = (level_q == '0);

    // A pop frees the slot in the same cycle, so push+pop while full still writes.
    assign rd_ok = pop_i & ~empty_o & ~flush_i;
    assign wr_ok = push_i & (~full_o | pop_i) & ~flush_i;

    assign evt_o.push = wr_ok;
    assign evt_o.pop  = rd_ok;
    assign evt_o.drop = push_i & full_o & ~pop_i & ~flush_i;

    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem_q[wp_q] <= wdat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rp_q    <= '0;
            wp_q    <= '0;
            level_q <= '0;
        end else if (flush_i) begin
            rp_q    <= wp_q;
            level_q <= '0;
        end else begin
            if (wr_ok) begin
                wp_q <= wp_q + 1'b1;
            end
            if (rd_ok) begin
                rp_q <= rp_q + 1'b1;
            end
            level_q <= level_q + (DEPTH_BITS + 1)'(wr_ok) - (DEPTH_BITS + 1)'(rd_ok);
        end
    end

    assign head_o  = mem_q[rp_q];
    assign level_o = level_q;

endmodule

// File: rtl/sia_rxq_wm.sv
// SIA V.4 receive queue: word-complete edge detect, overrun counting, watermark
// and character timeout around the sia_rxq_fifo storage.
module sia_rxq_wm
    import sia_rxq_wm_pkg::*;
#(
    parameter int DATA_BITS  = SIA_DATA_BITS,
    parameter int DEPTH_BITS = SIA_DEPTH_BITS,
    parameter int TMO_BITS   = SIA_TMO_BITS,
    parameter int OVC_BITS   = SIA_OVC_BITS
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [DATA_BITS-1:0]  rx_dat_i,
    input  logic                  rx_idle_i,
    input  logic                  pop_i,
    input  logic                  oe_i,
    input  logic                  flush_i,
    input  logic                  ovr_clr_i,
    input  logic [DEPTH_BITS:0]   wm_i,
    input  logic [TMO_BITS-1:0]   tmo_i,
    output logic [DATA_BITS-1:0]  dat_o,
    output logic [DEPTH_BITS:0]   level_o,
    output logic                  full_o,
    output logic                  not_empty_o,
    output logic                  wm_o,
    output logic                  tmo_o,
    output logic                  ovr_o,
    output logic [OVC_BITS-1:0]   ovr_cnt_o
);

    logic                 idle_dly_q;
    logic                 push;
    logic [DATA_BITS-1:0] head;
    logic [DEPTH_BITS:0]  level;
    logic                 full, empty;
    rxq_evt_t             evt;
    logic                 ovr_q;
    logic [OVC_BITS-1:0]  ovr_cnt_q;
    logic [TMO_BITS-1:0]  tmo_cnt_q;
    logic                 tmo_q;
    logic                 activity;
    logic                 tmo_hit;

    // Reset value 1 keeps a receiver that is already idle from pushing a stale word.
    assign push = rx_idle_i & ~idle_dly_q;

    sia_rxq_fifo #(
        .DATA_BITS  (DATA_BITS),
        .DEPTH_BITS (DEPTH_BITS)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .flush_i (flush_i),
        .push_i  (push),
        .pop_i   (pop_i),
        .wdat_i  (rx_dat_i),
        .head_o  (head),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty),
        .evt_o   (evt)
    );

    assign activity = push | evt.pop | flush_i;
    assign tmo_hit  = (tmo_i != '0) &&
                      (({1'b0, tmo_cnt_q} + (TMO_BITS + 1)'(1)) >= {1'b0, tmo_i});

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            idle_dly_q <= 1'b1;
            ovr_q      <= 1'b0;
            ovr_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            tmo_q      <= 1'b0;
        end else begin
            idle_dly_q <= rx_idle_i;

            // A drop in the same cycle as a clear leaves exactly one counted drop.
            if (evt.drop) begin
                ovr_q <= 1'b1;
                if (ovr_clr_i) begin
                    ovr_cnt_q <= OVC_BITS'(1);
                end else if (ovr_cnt_q != '1) begin
                    ovr_cnt_q <= ovr_cnt_q + 1'b1;
                end
            end else if (ovr_clr_i) begin
                ovr_q     <= 1'b0;
                ovr_cnt_q <= '0;
            end

            if (activity || empty) begin
                tmo_cnt_q <= '0;
            end else if (tmo_cnt_q != '1) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end

            if (activity) begin
                tmo_q <= 1'b0;
            end else if (!empty && tmo_hit) begin
                tmo_q <= 1'b1;
            end
        end
    end

    assign dat_o       = oe_i ? head : '0;
    assign level_o     = level;
    assign full_o      = full;
    assign not_empty_o = ~empty;
    assign wm_o        = (wm_i != '0) && (level >= wm_i);
    assign tmo_o       = tmo_q;
    assign ovr_o       = ovr_q;
    assign ovr_cnt_o   = ovr_cnt_q;

endmodule

// File: tb/tb_sia_rxq_wm.sv
// Self-checking bench for sia_rxq_wm: directed scenarios plus a randomized run
// against a queue-based reference model of the receive queue.
module tb_sia_rxq_wm;

    localparam int DEPTH = 16;

    logic        clk;
    logic        reset;
    logic [15:0] rx_dat;
    logic        rx_idle;
    logic        pop;
    logic        oe;
    logic        flush;
    logic        ovr_clr;
    logic [4:0]  wm;
    logic [15:0] tmo;
    logic [15:0] dat_o;
    logic [4:0]  level_o;
    logic        full_o;
    logic        not_empty_o;
    logic        wm_o;
    logic        tmo_o;
    logic        ovr_o;
    logic [7:0]  ovr_cnt_o;

    int n_cmp;
    int n_err;

    // Reference model state
    logic [15:0] exp_q[$];
    bit          m_idle_dly;
    bit          m_ovr;
    int          m_ovc;
    bit          m_tmo;
    int          m_quiet;

    sia_rxq_wm dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .rx_dat_i    (rx_dat),
        .rx_idle_i   (rx_idle),
        .pop_i       (pop),
        .oe_i        (oe),
        .flush_i     (flush),
        .ovr_clr_i   (ovr_clr),
        .wm_i        (wm),
        .tmo_i       (tmo),
        .dat_o       (dat_o),
        .level_o     (level_o),
        .full_o      (full_o),
        .not_empty_o (not_empty_o),
        .wm_o        (wm_o),
        .tmo_o       (tmo_o),
        .ovr_o       (ovr_o),
        .ovr_cnt_o   (ovr_cnt_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of one clock edge, using the inputs held across that edge.
    task automatic model_edge();
        bit push, pe, drop;
        int lvl;
        if (reset) begin
            exp_q.delete();
            m_idle_dly = 1'b1;
            m_ovr = 1'b0;
            m_ovc = 0;
            m_tmo = 1'b0;
            m_quiet = 0;
            return;
        end
        push = rx_idle && !m_idle_dly;
        m_idle_dly = rx_idle;
        lvl = exp_q.size();
        drop = 1'b0;
        if (flush) begin
            exp_q.delete();
            m_tmo = 1'b0;
            m_quiet = 0;
        end else begin
            pe = pop && (lvl > 0);
            drop = push && (lvl == DEPTH) && !pop;
            if (pe) void'(exp_q.pop_front());
            if (push && !drop) exp_q.push_back(rx_dat);
            if (push || pe || lvl == 0) m_quiet = 0;
            else m_quiet++;
            if (push || pe) m_tmo = 1'b0;
            else if (lvl != 0 && tmo != 0 && m_quiet >= int'(tmo)) m_tmo = 1'b1;
        end
        if (drop) begin
            m_ovr = 1'b1;
            m_ovc = ovr_clr ? 1 : ((m_ovc < 255) ? m_ovc + 1 : 255);
        end else if (ovr_clr) begin
            m_ovr = 1'b0;
            m_ovc = 0;
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic push_word(input logic [15:0] d, input bit with_pop);
        rx_idle = 1'b0;
        pop = 1'b0;
        tick();
        rx_dat = d;
        rx_idle = 1'b1;
        pop = with_pop;
        tick();
        pop = 1'b0;
    endtask

    task automatic pop_word();
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        ovr_clr = 1'b1;
        tick();
        flush = 1'b0;
        ovr_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx_idle = 1'b1;
        repeat (5) tick();
        reset = 1'b0;
        repeat (3) tick();
        n_cmp++; if (level_o !== 5'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", level_o); end
        n_cmp++; if (not_empty_o !== 1'b0) begin n_err++; $display("FAIL reset_not_empty: got %b want 0", not_empty_o); end
        n_cmp++; if (full_o !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full_o); end
        n_cmp++; if ({wm_o, tmo_o, ovr_o} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got wm/tmo/ovr=%b want 000", {wm_o, tmo_o, ovr_o}); end
        n_cmp++; if (ovr_cnt_o !== 8'd0) begin n_err++; $display("FAIL reset_ovr_cnt: got %0d want 0", ovr_cnt_o); end
        n_cmp++; if (dat_o !== 16'h0) begin n_err++; $display("FAIL reset_dat: got %h want 0000", dat_o); end
    endtask

    task automatic test_single();
        oe = 1'b1;
        push_word(16'hA55A, 1'b0);
        n_cmp++; if (dat_o !== 16'hA55A) begin n_err++; $display("FAIL single_dat: got %h want a55a", dat_o); end
        n_cmp++; if (level_o !== 5'd1) begin n_err++; $display("FAIL single_level: got %0d want 1", level_o); end
        pop_word();
        n_cmp++; if (level_o !== 5'd0 || not_empty_o !== 1'b0) begin n_err++; $display("FAIL single_pop: got level %0d ne %b want 0 0", level_o, not_empty_o); end
        pop_word();
        n_cmp++; if (level_o !== 5'd0) begin n_err++; $display("FAIL pop_empty: got %0d want 0", level_o); end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < DEPTH; i++) begin
            push_word(16'h1000 + 16'(i), 1'b0);
            if (i == DEPTH - 2) begin
                n_cmp++; if (full_o !== 1'b0) begin n_err++; $display("FAIL full_at_15: got %b want 0", full_o); end
            end
        end
        n_cmp++; if (full_o !== 1'b1 || level_o !== 5'd16) begin n_err++; $display("FAIL full_at_16: got full %b level %0d want 1 16", full_o, level_o); end
        push_word(16'hDEAD, 1'b0);
        n_cmp++; if (ovr_o !== 1'b1 || ovr_cnt_o !== 8'd1) begin n_err++; $display("FAIL ovr_first: got ovr %b cnt %0d want 1 1", ovr_o, ovr_cnt_o); end
        n_cmp++; if (dat_o !== 16'h1000 || level_o !== 5'd16) begin n_err++; $display("FAIL ovr_head: got %h level %0d want 1000 16", dat_o, level_o); end
        push_word(16'hBEEF, 1'b1);
        n_cmp++; if (level_o !== 5'd16 || ovr_cnt_o !== 8'd1) begin n_err++; $display("FAIL full_pushpop: got level %0d cnt %0d want 16 1", level_o, ovr_cnt_o); end
        n_cmp++; if (dat_o !== 16'h1001) begin n_err++; $display("FAIL full_pushpop_head: got %h want 1001", dat_o); end
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        n_cmp++; if (ovr_o !== 1'b0 || ovr_cnt_o !== 8'd0) begin n_err++; $display("FAIL ovr_clr: got ovr %b cnt %0d want 0 0", ovr_o, ovr_cnt_o); end
        // Drain in order to confirm the dropped word never entered.
        for (int i = 1; i < DEPTH; i++) begin
            n_cmp++; if (dat_o !== 16'h1000 + 16'(i)) begin n_err++; $display("FAIL drain_order: got %h want %h", dat_o, 16'h1000 + 16'(i)); end
            pop_word();
        end
        n_cmp++; if (dat_o !== 16'hBEEF) begin n_err++; $display("FAIL drain_last: got %h want beef", dat_o); end
        do_flush();
    endtask

    task automatic test_wm();
        wm = 5'd4;
        for (int i = 0; i < 3; i++) push_word(16'(i), 1'b0);
        n_cmp++; if (wm_o !== 1'b0) begin n_err++; $display("FAIL wm_below: got %b want 0", wm_o); end
        push_word(16'h3, 1'b0);
        n_cmp++; if (wm_o !== 1'b1) begin n_err++; $display("FAIL wm_at: got %b want 1", wm_o); end
        pop_word();
        n_cmp++; if (wm_o !== 1'b0) begin n_err++; $display("FAIL wm_pop: got %b want 0", wm_o); end
        for (int i = 0; i < 13; i++) push_word(16'h40 + 16'(i), 1'b0);
        wm = 5'd0;
        #1;
        n_cmp++; if (wm_o !== 1'b0 || level_o !== 5'd16) begin n_err++; $display("FAIL wm_disabled: got wm %b level %0d want 0 16", wm_o, level_o); end
        wm = 5'd16;
        #1;
        n_cmp++; if (wm_o !== 1'b1) begin n_err++; $display("FAIL wm_16: got %b want 1", wm_o); end
        wm = 5'd0;
        do_flush();
    endtask

    task automatic test_tmo();
        tmo = 16'd10;
        push_word(16'h1234, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_cmp++; if (tmo_o !== (k == 10)) begin n_err++; $display("FAIL tmo_cycle%0d: got %b want %b", k, tmo_o, k == 10); end
        end
        pop_word();
        n_cmp++; if (tmo_o !== 1'b0 || level_o !== 5'd0) begin n_err++; $display("FAIL tmo_pop: got tmo %b level %0d want 0 0", tmo_o, level_o); end
        repeat (15) tick();
        n_cmp++; if (tmo_o !== 1'b0) begin n_err++; $display("FAIL tmo_empty: got %b want 0", tmo_o); end
        push_word(16'h5678, 1'b0);
        repeat (5) tick();
        n_cmp++; if (tmo_o !== 1'b0) begin n_err++; $display("FAIL tmo_before_lower: got %b want 0", tmo_o); end
        tmo = 16'd3;
        tick();
        n_cmp++; if (tmo_o !== 1'b1) begin n_err++; $display("FAIL tmo_lowered: got %b want 1", tmo_o); end
        push_word(16'h9ABC, 1'b0);
        n_cmp++; if (tmo_o !== 1'b0) begin n_err++; $display("FAIL tmo_push_clr: got %b want 0", tmo_o); end
        tmo = 16'd0;
        do_flush();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) push_word(16'h200 + 16'(i), 1'b0);
        rx_idle = 1'b0;
        tick();
        rx_dat = 16'hFEED;
        rx_idle = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++; if (level_o !== 5'd0 || not_empty_o !== 1'b0) begin n_err++; $display("FAIL flush_push: got level %0d ne %b want 0 0", level_o, not_empty_o); end
        repeat (3) tick();
        n_cmp++; if (level_o !== 5'd0) begin n_err++; $display("FAIL flush_hold: got %0d want 0", level_o); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < DEPTH; i++) push_word(16'(i), 1'b0);
        for (int i = 1; i <= 256; i++) begin
            push_word(16'hEEEE, 1'b0);
            if (i == 254) begin
                n_cmp++; if (ovr_cnt_o !== 8'hFE) begin n_err++; $display("FAIL ovr_cnt_254: got %h want fe", ovr_cnt_o); end
            end
        end
        n_cmp++; if (ovr_cnt_o !== 8'hFF || ovr_o !== 1'b1) begin n_err++; $display("FAIL ovr_sat: got cnt %h ovr %b want ff 1", ovr_cnt_o, ovr_o); end
        ovr_clr = 1'b1;
        push_word(16'hEEEE, 1'b0);
        ovr_clr = 1'b0;
        n_cmp++; if (ovr_cnt_o !== 8'd1 || ovr_o !== 1'b1) begin n_err++; $display("FAIL ovr_clr_race: got cnt %0d ovr %b want 1 1", ovr_cnt_o, ovr_o); end
        do_flush();
    endtask

    task automatic test_random();
        logic [15:0] exp_dat;
        for (int c = 0; c < 3000; c++) begin
            reset   = ($urandom_range(0, 599) == 0);
            rx_idle = $urandom_range(0, 1);
            rx_dat  = 16'($urandom);
            pop     = ($urandom_range(0, 9) < 3);
            flush   = ($urandom_range(0, 79) == 0);
            ovr_clr = ($urandom_range(0, 39) == 0);
            oe      = $urandom_range(0, 1);
            wm      = 5'($urandom_range(0, 16));
            if ($urandom_range(0, 99) == 0) tmo = 16'($urandom_range(0, 12));
            tick();
            exp_dat = (oe && exp_q.size() > 0) ? exp_q[0] : 16'h0;
            n_cmp++; if (level_o !== 5'(exp_q.size())) begin n_err++; $display("FAIL rnd_level c%0d: got %0d want %0d", c, level_o, exp_q.size()); end
            n_cmp++; if (full_o !== (exp_q.size() == DEPTH) || not_empty_o !== (exp_q.size() != 0)) begin n_err++; $display("FAIL rnd_full_ne c%0d: got %b%b", c, full_o, not_empty_o); end
            n_cmp++; if (wm_o !== (wm != 0 && exp_q.size() >= int'(wm))) begin n_err++; $display("FAIL rnd_wm c%0d: got %b wm %0d level %0d", c, wm_o, wm, exp_q.size()); end
            n_cmp++; if (tmo_o !== m_tmo) begin n_err++; $display("FAIL rnd_tmo c%0d: got %b want %b", c, tmo_o, m_tmo); end
            n_cmp++; if (ovr_o !== m_ovr || ovr_cnt_o !== 8'(m_ovc)) begin n_err++; $display("FAIL rnd_ovr c%0d: got %b %0d want %b %0d", c, ovr_o, ovr_cnt_o, m_ovr, m_ovc); end
            if (!oe || exp_q.size() > 0) begin
                n_cmp++; if (dat_o !== exp_dat) begin n_err++; $display("FAIL rnd_dat c%0d: got %h want %h", c, dat_o, exp_dat); end
            end
        end
        reset = 1'b0;
        flush = 1'b0;
        ovr_clr = 1'b0;
        pop = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        rx_dat = 16'h0;
        rx_idle = 1'b1;
        pop = 1'b0;
        oe = 1'b0;
        flush = 1'b0;
        ovr_clr = 1'b0;
        wm = 5'd0;
        tmo = 16'd0;
        m_idle_dly = 1'b1;
        m_ovr = 1'b0;
        m_ovc = 0;
        m_tmo = 1'b0;
        m_quiet = 0;
        test_reset();
        test_single();
        test_overrun();
        test_wm();
        test_tmo();
        test_flush();
        test_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
